// File: rtl/mips_run_controller.sv
// Run/step sequencer gating mips_core via a registered clock-enable: free-run, single-step, run-N.
// Latency: start to first core_en is one cycle; all outputs registered; no backpressure, host polls busy/done.
module mips_run_controller #(
  parameter int PC_W           = 32,
  parameter int CYCLE_W        = 16,
  parameter int DEFAULT_CYCLES = 9,
  parameter int STALL_CYCLES   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CYCLE_W-1:0] cycle_limit,
  input  logic               step_req,
  input  logic               abort,
  input  logic [PC_W-1:0]    core_pc,
  input  logic               core_halt,
  output logic               core_en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_cause,
  output logic [CYCLE_W-1:0] cycles_run,
  output logic [PC_W-1:0]    last_pc
);

  localparam int SW = (STALL_CYCLES < 2) ? 1 : $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  localparam logic [1:0] CAUSE_LIMIT = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_ABORT = 2'd2;
  localparam logic [1:0] CAUSE_ERR   = 2'd3;

  typedef enum logic [2:0] {IDLE, RUN, STEP_WAIT, STEP, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic [CYCLE_W-1:0] limit_q, limit_nxt;
  logic [SW-1:0]      stall_q, stall_nxt, stall_inc;
  logic [CYCLE_W-1:0] cycles_nxt, cycles_sat, limit_eff, run_limit;
  logic [CYCLE_W:0]   cycles_inc;
  logic [PC_W-1:0]    last_pc_nxt;
  logic [1:0]         cause_nxt, term_cause;
  logic               core_en_nxt, busy_nxt, done_nxt;
  logic               halt_hit, limit_hit, term;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mode_q     <= 2'd0;
      limit_q    <= '0;
      stall_q    <= '0;
      core_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_cause <= CAUSE_LIMIT;
      cycles_run <= '0;
      last_pc    <= '0;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode_nxt;
      limit_q    <= limit_nxt;
      stall_q    <= stall_nxt;
      core_en    <= core_en_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      done_cause <= cause_nxt;
      cycles_run <= cycles_nxt;
      last_pc    <= last_pc_nxt;
    end
  end

  always_comb begin
    cycles_inc = {1'b0, cycles_run} + (CYCLE_W+1)'(1);
    cycles_sat = (&cycles_run) ? cycles_run : cycles_inc[CYCLE_W-1:0];
    limit_eff  = (cycle_limit == '0) ? CYCLE_W'(DEFAULT_CYCLES) : cycle_limit;
    // Free-run has no user budget; it stops just before the counter saturates.
    run_limit  = (mode_q == 2'd0) ? {CYCLE_W{1'b1}} : limit_q;
    stall_inc  = (core_pc == last_pc) ? (stall_q + SW'(1)) : '0;
    halt_hit   = core_halt || (stall_inc == STALL_MAX);
    limit_hit  = (cycles_inc == {1'b0, run_limit});

    term       = 1'b1;
    term_cause = CAUSE_LIMIT;
    if (abort)          term_cause = CAUSE_ABORT;
    else if (halt_hit)  term_cause = CAUSE_HALT;
    else if (limit_hit) term_cause = CAUSE_LIMIT;
    else                term       = 1'b0;

    state_nxt   = state;
    mode_nxt    = mode_q;
    limit_nxt   = limit_q;
    stall_nxt   = stall_q;
    cycles_nxt  = cycles_run;
    last_pc_nxt = last_pc;
    cause_nxt   = done_cause;
    core_en_nxt = 1'b0;

    if (core_en) begin
      cycles_nxt  = cycles_sat;
      last_pc_nxt = core_pc;
      stall_nxt   = stall_inc;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          mode_nxt   = mode;
          limit_nxt  = limit_eff;
          cycles_nxt = '0;
          stall_nxt  = '0;
          cause_nxt  = CAUSE_LIMIT;
          case (mode)
            2'd1: state_nxt = STEP_WAIT;
            2'd3: begin
              state_nxt = DONE;
              cause_nxt = CAUSE_ERR;
            end
            default: begin
              state_nxt   = RUN;
              core_en_nxt = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        if (term) begin
          state_nxt = DONE;
          cause_nxt = term_cause;
        end else begin
          core_en_nxt = 1'b1;
        end
      end
      STEP_WAIT: begin
        if (abort) begin
          state_nxt = DONE;
          cause_nxt = CAUSE_ABORT;
        end else if (step_req) begin
          state_nxt   = STEP;
          core_en_nxt = 1'b1;
        end
      end
      STEP: begin
        if (term) begin
          state_nxt = DONE;
          cause_nxt = term_cause;
        end else begin
          state_nxt = STEP_WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN) || (state_nxt == STEP_WAIT) || (state_nxt == STEP);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller: behavioural model compared every cycle plus literal checks.
module tb_mips_run_controller;

  logic        clock, reset_n, start, step_req, abort, core_halt;
  logic [1:0]  mode;
  logic [15:0] cycle_limit;
  logic [31:0] core_pc;
  logic        core_en, busy, done;
  logic [1:0]  done_cause;
  logic [15:0] cycles_run;
  logic [31:0] last_pc;

  mips_run_controller dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .cycle_limit(cycle_limit), .step_req(step_req), .abort(abort),
    .core_pc(core_pc), .core_halt(core_halt), .core_en(core_en),
    .busy(busy), .done(done), .done_cause(done_cause),
    .cycles_run(cycles_run), .last_pc(last_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is "active" or not; en says the core runs this cycle.
  logic        m_busy, m_en, m_done, m_adv, m_step, fin;
  logic [1:0]  m_cause, why;
  int unsigned m_cnt, m_lim, m_same;
  logic [31:0] m_last;

  initial begin
    m_busy = 0; m_en = 0; m_done = 0; m_adv = 0; m_step = 0;
    m_cause = 0; m_cnt = 0; m_lim = 0; m_same = 0; m_last = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_busy = 0; m_en = 0; m_done = 0; m_adv = 0; m_step = 0;
        m_cause = 0; m_cnt = 0; m_lim = 0; m_same = 0; m_last = 0;
      end else begin
        m_adv = m_en;
        if (m_busy) begin
          fin = 0; why = 0;
          if (m_en) begin
            if (m_cnt < 65535) m_cnt++;
            m_same = (core_pc == m_last) ? m_same + 1 : 0;
            m_last = core_pc;
          end
          if (abort) begin fin = 1; why = 2; end
          else if (m_en && (core_halt || m_same >= 2)) begin fin = 1; why = 1; end
          else if (m_en && m_cnt == m_lim) begin fin = 1; why = 0; end
          if (fin) begin
            m_busy = 0; m_done = 1; m_en = 0; m_cause = why;
          end else if (m_step) begin
            m_en = !m_en && step_req;
          end else begin
            m_en = 1;
          end
        end else if (start) begin
          m_cnt = 0; m_same = 0; m_done = 0; m_cause = 0;
          m_step = (mode == 2'd1);
          m_lim = (mode == 2'd0) ? 65535 : ((cycle_limit == 0) ? 9 : cycle_limit);
          if (mode == 2'd3) begin
            m_done = 1; m_cause = 3; m_en = 0;
          end else begin
            m_busy = 1; m_en = (mode != 2'd1);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("core_en",    core_en,    m_en);
      chk("busy",       busy,       m_busy);
      chk("done",       done,       m_done);
      chk("done_cause", done_cause, m_cause);
      chk("cycles_run", cycles_run, m_cnt[15:0]);
      chk("last_pc",    last_pc,    m_last);
    end
  end

  // Simple core stand-in: PC advances by 4 after each enabled cycle unless parked.
  logic        stop_en, halt_en;
  logic [31:0] pc_stop, halt_pc;

  task automatic tick();
    @(negedge clock);
    if (core_en) en_cnt++;
    if (m_adv && !(stop_en && core_pc == pc_stop)) core_pc = core_pc + 32'd4;
    core_halt = halt_en && (core_pc == halt_pc);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [15:0] lim);
    mode = m; cycle_limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset_n = 0; start = 0; mode = 0; cycle_limit = 0; step_req = 0; abort = 0;
    core_pc = 0; core_halt = 0; stop_en = 0; halt_en = 0; pc_stop = 0; halt_pc = 0;
    repeat (2) @(negedge clock);
    chk("rst_core_en", core_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles_run, 0);
    #2 reset_n = 1;
    tick();

    // Reset mid-run
    start_run(2'd2, 16'd20);
    repeat (5) tick();
    #2 reset_n = 0;
    #1;
    chk("midrst_core_en", core_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cause", done_cause, 0);
    chk("midrst_cycles", cycles_run, 0);
    chk("midrst_last_pc", last_pc, 0);
    tick(); tick();
    #2 reset_n = 1;
    tick();

    // Run-N with default budget; abort alongside start in IDLE is ignored
    core_pc = 32'h100; en_cnt = 0; abort = 1;
    start_run(2'd2, 16'd0);
    abort = 0;
    run_until_done("runn", 100);
    tick();
    chk("runn_en_cycles", en_cnt, 9);
    chk("runn_cause", done_cause, 0);
    chk("runn_cycles", cycles_run, 9);
    chk("runn_last_pc", last_pc, 32'h120);

    // Explicit halt on the 4th enabled cycle
    core_pc = 32'h4; halt_en = 1; halt_pc = 32'h10;
    start_run(2'd0, 16'd0);
    run_until_done("halt", 100);
    halt_en = 0; core_halt = 0;
    tick();
    chk("halt_cause", done_cause, 1);
    chk("halt_cycles", cycles_run, 4);
    chk("halt_last_pc", last_pc, 32'h10);

    // PC stall: 0,4,8,8,8
    core_pc = 32'h0; stop_en = 1; pc_stop = 32'h8;
    start_run(2'd0, 16'd0);
    run_until_done("stall", 100);
    stop_en = 0;
    tick();
    chk("stall_cause", done_cause, 1);
    chk("stall_cycles", cycles_run, 5);
    chk("stall_last_pc", last_pc, 32'h8);

    // Halt and abort together: abort wins
    core_pc = 32'h40;
    start_run(2'd0, 16'd0);
    tick(); tick();
    abort = 1; core_halt = 1;
    tick();
    abort = 0; core_halt = 0;
    tick();
    chk("abort_cause", done_cause, 2);
    chk("abort_cycles", cycles_run, 3);

    // Single-step, limit 3
    core_pc = 32'h200; en_cnt = 0;
    start_run(2'd1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      step_req = 1; tick();
      step_req = 0; tick();
      tick();
    end
    chk("step_en_cycles", en_cnt, 3);
    chk("step_done", done, 1);
    chk("step_cause", done_cause, 0);
    chk("step_cycles", cycles_run, 3);
    step_req = 1; tick(); tick(); step_req = 0; tick();
    chk("step_extra_en", en_cnt, 3);
    chk("step_extra_done", done, 1);

    // Abort and step_req together in STEP_WAIT: abort wins, no step
    en_cnt = 0;
    start_run(2'd1, 16'd0);
    step_req = 1; abort = 1;
    tick();
    step_req = 0; abort = 0;
    tick(); tick();
    chk("stepabort_en", en_cnt, 0);
    chk("stepabort_cause", done_cause, 2);
    chk("stepabort_cycles", cycles_run, 0);

    // Reserved mode, then restart from DONE
    en_cnt = 0;
    start_run(2'd3, 16'd5);
    tick(); tick();
    chk("err_done", done, 1);
    chk("err_cause", done_cause, 3);
    chk("err_en", en_cnt, 0);
    start_run(2'd2, 16'd2);
    chk("restart_cleared", cycles_run, 0);
    run_until_done("restart", 50);
    tick();
    chk("restart_en", en_cnt, 2);
    chk("restart_cycles", cycles_run, 2);
    chk("restart_cause", done_cause, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
Synthesizable run/step sequencer that gates the MIPS core through a clock-enable instead of hand-toggled bench clocks. It supports free-run, single-step and run-N-cycles modes. Runs end on halt detection (explicit halt or PC stall), abort, or cycle budget. It sits between the bench or debug host and mips_core, and reports cycle count, final PC and termination cause.

Parameters:
PC_W, 32, width of core PC and last_pc
CYCLE_W, 16, width of cycle_limit and cycles_run
DEFAULT_CYCLES, 9, budget used when cycle_limit==0 in run-N or step mode
STALL_CYCLES, 2, consecutive enabled cycles with unchanged PC that count as halt (>=1)

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin run; sampled in IDLE or DONE only
mode  input  2  0 free-run, 1 single-step, 2 run-N, 3 reserved
cycle_limit  input  CYCLE_W  budget for modes 1/2; 0 selects DEFAULT_CYCLES
step_req  input  1  request one core cycle in single-step mode
abort  input  1  terminate the current run
core_pc  input  PC_W  current core PC
core_halt  input  1  core halt/syscall-exit indication
core_en  output  1  core clock-enable, registered
busy  output  1  high in RUN, STEP_WAIT, STEP
done  output  1  high in DONE
done_cause  output  2  0 LIMIT, 1 HALT, 2 ABORT, 3 ERR
cycles_run  output  CYCLE_W  enabled cycles executed in current/last run
last_pc  output  PC_W  core_pc sampled on the last enabled cycle

Behaviour:
- Reset (async, any state): state=IDLE; core_en=0, busy=0, done=0, done_cause=0, cycles_run=0, last_pc=0, stall counter=0, latched limit=0. core_en drops immediately on reset_n low, including mid-run.
- States: IDLE, RUN, STEP_WAIT, STEP, DONE.
- Start sequence:
  - start=1 in IDLE or DONE latches mode and the effective limit, clears cycles_run, stall counter and done, and moves to the next state at the same edge.
  - Next state: mode 0/2 -> RUN with core_en=1 from the next cycle. mode 1 -> STEP_WAIT. mode 3 -> DONE with cause ERR.
  - start is ignored while busy.
- Enabled-cycle processing: every edge with core_en=1 is an enabled cycle and does the following:
  - cycles_run += 1, saturating at all-ones.
  - last_pc <= core_pc.
  - Stall counter increments if core_pc == last_pc, else resets to 0.
- Termination is evaluated on each enabled-cycle edge. Priority: abort > halt > limit.
  - abort=1 in any busy state (sampled every busy edge, not only enabled ones) -> DONE, cause ABORT.
  - core_halt=1, or stall counter reaching STALL_CYCLES -> DONE, cause HALT.
  - Modes 1/2: cycles_run+1 == limit -> DONE, cause LIMIT. Mode 0: cycles_run+1 == all-ones -> DONE, cause LIMIT.
  - On the terminating edge core_en<=0. The terminating cycle is counted, so run-N yields exactly limit core_en cycles.
- RUN: core_en held 1 continuously until termination.
- Single-step:
  - step_req=1 in STEP_WAIT -> STEP. core_en=1 for exactly one cycle, then back to STEP_WAIT, or DONE if termination hits.
  - step_req held high produces one step every 2 cycles (STEP_WAIT/STEP alternate).
  - step_req is ignored outside STEP_WAIT.
- DONE: done=1, busy=0, core_en=0. done_cause, cycles_run and last_pc are held until the next start or reset.
- Outputs are all registered; no combinational path from inputs to outputs.
- Simultaneous events:
  - start with abort in IDLE: start wins; abort has no effect outside busy.
  - abort and step_req in STEP_WAIT: abort wins, no step issued.

Test Plan:
- Reset mid-RUN: mode 2, limit 20, assert reset_n=0 after 5 enabled cycles -> core_en falls immediately; all outputs 0; state IDLE.
- Run-N: mode 2, cycle_limit=0 -> core_en high exactly 9 cycles; done=1, cause LIMIT, cycles_run=9.
- Explicit halt: mode 0, core_halt=1 on 4th enabled cycle with core_pc=0x0000_0010 -> done, cause HALT, cycles_run=4, last_pc=0x10.
- PC stall: mode 0, PC 0x0,0x4,0x8,0x8,0x8 -> HALT after 5th enabled cycle; core_halt and abort asserted together also -> cause ABORT.
- Single-step: mode 1, limit 3, three step_req pulses -> three 1-cycle core_en pulses; done after 3rd, cause LIMIT. Extra step_req in DONE has no effect.
- Reserved and restart: mode 3 -> DONE, cause ERR, core_en never high. start again with mode 2, limit 2 in DONE -> cycles_run cleared, 2 enabled cycles.
